// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader that assembles 32-bit words into instruction memory
module program_loader #(
  parameter int          MAX_WORDS = 129,
  parameter logic [31:0] HALT_WORD = 32'h00100073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [7:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic [7:0]  word_count
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;
  logic        w_accept;
  logic        w_last_word;

  // byte_ready is a register, so acceptance never feeds back into the handshake combinationally
  assign w_accept    = byte_valid && byte_ready;
  assign w_last_word = (wr_data == HALT_WORD) || (wr_idx == LAST_IDX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = LOAD;
      LOAD:  if (w_accept && (r_byte_cnt == 2'd3)) w_next = WRITE;
      WRITE: w_next = w_last_word ? DONE : LOAD;
      DONE:  if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_idx     <= 8'd0;
      wr_data    <= 32'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      word_count <= 8'd0;
    end else begin
      // status outputs are registered copies of the state being entered
      byte_ready <= (w_next == LOAD);
      wr_en      <= (w_next == WRITE);
      done       <= (w_next == DONE);
      cpu_hold   <= (w_next != DONE);

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_byte_cnt <= 2'd0;
            wr_idx     <= 8'd0;
            word_count <= 8'd0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0:    r_asm[7:0]   <= byte_data;
              2'd1:    r_asm[15:8]  <= byte_data;
              2'd2:    r_asm[23:16] <= byte_data;
              default: wr_data      <= {byte_data, r_asm};
            endcase
          end
        end
        WRITE: begin
          word_count <= word_count + 8'd1;
          if (!w_last_word) begin
            wr_idx     <= wr_idx + 8'd1;
            r_byte_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_idx;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic [7:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [39:0] wq[$];
  int gap_max = 0;

  localparam logic [31:0] HALT = 32'h00100073;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back({wr_idx, wr_data});
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    int gap;
    gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    idle_cycles(gap);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL byte_ready_timeout: byte %h never accepted, got byte_ready=%b required 1", b, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    idle_cycles(3);
    checks++;
    if ({byte_ready, wr_en, wr_idx, wr_data, word_count, done, cpu_hold} !== {1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got br=%b we=%b idx=%0d data=%h wc=%0d done=%b hold=%b required 0 0 0 0 0 0 1",
               byte_ready, wr_en, wr_idx, wr_data, word_count, done, cpu_hold);
    end
    reset = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hAA;
    idle_cycles(5);
    checks++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || wq.size() != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got br=%b hold=%b writes=%0d required 0 1 0", byte_ready, cpu_hold, wq.size());
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    wq.delete();
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL basic_enter_load: got br=%b hold=%b required 1 1", byte_ready, cpu_hold);
    end
    send_word(32'h00000013);
    send_word(HALT);
    wait_done();
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== {8'd0, 32'h00000013}) begin
        errors++;
        $display("FAIL basic_word0: got %h required %h", wq[0], {8'd0, 32'h00000013});
      end
      checks++;
      if (wq[1] !== {8'd1, HALT}) begin
        errors++;
        $display("FAIL basic_word1: got %h required %h", wq[1], {8'd1, HALT});
      end
    end
    checks++;
    if (cpu_hold !== 1'b0 || word_count !== 8'd2 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_state: got hold=%b wc=%0d br=%b required 0 2 0", cpu_hold, word_count, byte_ready);
    end
  endtask

  task automatic test_done_ignores_bytes();
    byte_valid = 1'b1; byte_data = 8'h55;
    idle_cycles(4);
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0 || wq.size() != 2 || word_count !== 8'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignores_bytes: got br=%b writes=%0d wc=%0d done=%b required 0 2 2 1",
               byte_ready, wq.size(), word_count, done);
    end
  endtask

  task automatic test_random_valid();
    wq.delete();
    pulse_start();
    checks++;
    if (done !== 1'b0 || word_count !== 8'd0 || wr_idx !== 8'd0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b wc=%0d idx=%0d hold=%b required 0 0 0 1",
               done, word_count, wr_idx, cpu_hold);
    end
    gap_max = 3;
    send_word(32'h11223344);
    send_word(32'hA5A55A5A);
    send_word(HALT);
    gap_max = 0;
    wait_done();
    checks++;
    if (wq.size() != 3) begin
      errors++;
      $display("FAIL random_write_count: got %0d required 3", wq.size());
    end else begin
      checks++;
      if (wq[0] !== {8'd0, 32'h11223344} || wq[1] !== {8'd1, 32'hA5A55A5A} || wq[2] !== {8'd2, HALT}) begin
        errors++;
        $display("FAIL random_words: got %h %h %h required %h %h %h", wq[0], wq[1], wq[2],
                 {8'd0, 32'h11223344}, {8'd1, 32'hA5A55A5A}, {8'd2, HALT});
      end
    end
    checks++;
    if (word_count !== 8'd3) begin
      errors++;
      $display("FAIL random_word_count: got %0d required 3", word_count);
    end
  endtask

  task automatic test_start_mid_load();
    wq.delete();
    pulse_start();
    send_byte(8'hEF);
    send_byte(8'hBE);
    pulse_start();
    checks++;
    if (wr_idx !== 8'd0 || byte_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_mid_load_state: got idx=%0d br=%b done=%b required 0 1 0", wr_idx, byte_ready, done);
    end
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_word(HALT);
    wait_done();
    checks++;
    if (wq.size() != 2 || wq[0] !== {8'd0, 32'hDEADBEEF} || wq[1] !== {8'd1, HALT}) begin
      errors++;
      $display("FAIL start_mid_load_words: got n=%0d first=%h required n=2 first=%h",
               wq.size(), (wq.size() > 0) ? wq[0] : 40'd0, {8'd0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_reset_mid_load();
    wq.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_mid_load: got hold=%b br=%b we=%b done=%b required 1 0 0 0",
               cpu_hold, byte_ready, wr_en, done);
    end
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(2);
    checks++;
    if (wq.size() != 0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write: got writes=%0d br=%b required 0 0", wq.size(), byte_ready);
    end
    pulse_start();
    send_word(32'h00500093);
    send_word(HALT);
    wait_done();
    checks++;
    if (wq.size() != 2 || wq[0] !== {8'd0, 32'h00500093}) begin
      errors++;
      $display("FAIL reset_fresh_word: got n=%0d first=%h required n=2 first=%h",
               wq.size(), (wq.size() > 0) ? wq[0] : 40'd0, {8'd0, 32'h00500093});
    end
  endtask

  task automatic test_max_words();
    int bad;
    wq.delete();
    pulse_start();
    for (int i = 0; i < 129; i++) send_word(32'hA0000000 | 32'(i));
    wait_done();
    idle_cycles(5);
    checks++;
    if (wq.size() != 129) begin
      errors++;
      $display("FAIL max_write_count: got %0d required 129", wq.size());
    end
    bad = 0;
    for (int i = 0; i < wq.size() && i < 129; i++) begin
      if (wq[i] !== {8'(i), 32'hA0000000 | 32'(i)}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL max_word_contents: got %0d wrong entries required 0", bad);
    end
    checks++;
    if (wr_idx !== 8'd128 || word_count !== 8'd129 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL max_final_state: got idx=%0d wc=%0d done=%b hold=%b required 128 129 1 0",
               wr_idx, word_count, done, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_done_ignores_bytes();
    test_random_valid();
    test_start_mid_load();
    test_reset_mid_load();
    test_max_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 129, SHALL be the instruction memory depth in 32-bit words.
REQ-002 Parameter HALT_WORD, default 32'h00100073 (EBREAK), SHALL be the word that terminates a load.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: begins a load when sampled high in IDLE or DONE.
REQ-006 Port byte_valid, input, 1: byte_data is valid this cycle.
REQ-007 Port byte_data, input, 8: program byte stream, little-endian within each word.
REQ-008 Port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-009 Port wr_en, output, 1: single-cycle write strobe to instruction memory.
REQ-010 Port wr_idx, output, 8: word index, the same index the fetch side derives from read address bits [9:2].
REQ-011 Port wr_data, output, 32: assembled instruction word.
REQ-012 Port cpu_hold, output, 1: keeps the core stalled while memory is invalid.
REQ-013 Port done, output, 1: load complete.
REQ-014 Port word_count, output, 8: number of words written in the current or last load.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, WRITE, DONE.
REQ-016 A byte SHALL be accepted only on a cycle with byte_valid && byte_ready; byte_valid without byte_ready SHALL have no effect.
REQ-017 byte_ready SHALL be 1 only in LOAD and SHALL be registered, with no combinational path from byte_valid.
REQ-018 IDLE -> LOAD on start=1: byte counter=0, wr_idx=0, word_count=0.
REQ-019 In LOAD, the k-th accepted byte (k=0..3) SHALL be stored in assembly bits [8k+7:8k].
REQ-020 On acceptance of byte 3, the FSM SHALL go to WRITE; the next cycle SHALL have wr_en=1 and wr_data equal to the assembled word.
REQ-021 wr_en SHALL be high for exactly one cycle per word; wr_idx and wr_data SHALL be stable while wr_en=1.
REQ-022 Leaving WRITE, word_count SHALL increment by 1.
REQ-023 Leaving WRITE, if wr_data==HALT_WORD or wr_idx==MAX_WORDS-1, the FSM SHALL go to DONE; otherwise it SHALL go to LOAD with wr_idx+1 and byte counter 0.
REQ-024 wr_idx SHALL never exceed MAX_WORDS-1 and SHALL never wrap to 0 within a load.
REQ-025 In DONE: done=1, cpu_hold=0, byte_ready=0; start=1 SHALL restart as in REQ-018 and clear done on the next cycle.
REQ-026 cpu_hold SHALL be 1 in IDLE, LOAD and WRITE.
REQ-027 start SHALL be ignored in LOAD and WRITE.
REQ-028 A partial word (1-3 bytes) SHALL never be written; it SHALL be retained until completed or reset.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset=1 the block SHALL asynchronously enter IDLE with byte_ready=0, wr_en=0, wr_idx=0, wr_data=0, word_count=0, done=0, cpu_hold=1.
REQ-031 Reset during LOAD or WRITE SHALL discard the partial word and abort any pending write; no wr_en pulse SHALL occur after reset asserts.
REQ-032 After reset deassertion, the block SHALL stay in IDLE until start=1.

Verification
REQ-033 start; bytes 13,00,00,00, 73,00,10,00 -> wr_en at idx 0 data 32'h00000013, at idx 1 data 32'h00100073; then done=1, cpu_hold=0, word_count=2.
REQ-034 byte_valid toggled randomly over 3 words -> exactly 3 wr_en pulses with correct words; no byte lost or duplicated.
REQ-035 129 non-halt words -> last write at idx 128, then DONE with word_count=129 and no idx-0 wrap write.
REQ-036 Reset asserted after 2 bytes of word 0 -> immediately IDLE, cpu_hold=1, no wr_en; after restart, 4 fresh bytes -> idx 0 holds the new word only.
REQ-037 start pulsed mid-LOAD -> no effect on wr_idx or byte counter; start in DONE -> new load from idx 0 with done cleared.
REQ-038 byte_valid=1 in IDLE, WRITE or DONE -> byte_ready=0 and no byte captured.
